// File: rtl/mem_responder.sv
// mem_responder: snooping memory model. It answers cache read misses after a
// fixed latency, absorbs write-backs in every state, lets a cache intervention
// abort a pending access, and counts read misses it had to drop while busy.
module mem_responder #(
  parameter logic [1:0] ReadMiss  = 2'b01,
  parameter logic [1:0] ReadHit   = 2'b10,
  parameter logic [1:0] WriteBack = 2'b11,
  parameter int         LATENCY   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [8:0] bus_in,
  input  logic       bus_valid,
  output logic [8:0] resp_out,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  // Out-of-range latencies fall back to a single cycle.
  localparam logic [3:0] LatEff = (LATENCY >= 1 && LATENCY <= 15) ? 4'(LATENCY) : 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] tag_q;
  logic [3:0] cnt_q;
  logic [8:0] resp_out_q;
  logic       resp_valid_q;
  logic [3:0] drop_q;
  logic [3:0] mem_q [8];

  logic [1:0] code_in;
  logic [2:0] tag_in;
  logic [3:0] val_in;
  logic       rm_d;
  logic       rh_d;
  logic       wb_d;
  logic [3:0] rd_val_d;

  assign code_in = bus_in[8:7];
  assign tag_in  = bus_in[6:4];
  assign val_in  = bus_in[3:0];

  // Decode the snooped transaction and form the reply value with write-back
  // forwarding so a same-edge write to the latched tag wins over the old data.
  always_comb begin
    rm_d     = bus_valid && (code_in != 2'b00) && (code_in == ReadMiss);
    rh_d     = bus_valid && (code_in != 2'b00) && (code_in == ReadHit);
    wb_d     = bus_valid && (code_in != 2'b00) && (code_in == WriteBack);
    rd_val_d = (wb_d && (tag_in == tag_q)) ? val_in : mem_q[tag_q];
  end

  // Control FSM, memory array, reply register and drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tag_q        <= 3'd0;
      cnt_q        <= 4'd0;
      resp_out_q   <= 9'd0;
      resp_valid_q <= 1'b0;
      drop_q       <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= 4'(i);
      end
    end else begin
      if (wb_d) begin
        mem_q[tag_in] <= val_in;
      end

      // Any read miss seen while an access is outstanding is lost.
      if (rm_d && (state_q != IDLE) && (drop_q != 4'd15)) begin
        drop_q <= drop_q + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (rm_d) begin
            tag_q   <= tag_in;
            cnt_q   <= LatEff;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (rh_d && (tag_in == tag_q)) begin
            // Another cache supplied the line; abandon the access.
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else if (cnt_q == 4'd1) begin
            cnt_q        <= 4'd0;
            resp_out_q   <= {ReadHit, tag_q, rd_val_d};
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          cnt_q        <= 4'd0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_out   = resp_out_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY=2.
module tb_mem_responder;

  logic       clock;
  logic       reset_n;
  logic [8:0] bus_in;
  logic       bus_valid;
  logic [8:0] resp_out;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;
  logic [3:0] drop_cnt;

  int tests;
  int fails;

  mem_responder #(.LATENCY(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus_in     (bus_in),
    .bus_valid  (bus_valid),
    .resp_out   (resp_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] bw(input logic [1:0] code, input logic [2:0] tag,
                                    input logic [3:0] val);
    return {code, tag, val};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [8:0] w);
    bus_in    = w;
    bus_valid = 1'b1;
  endtask

  task automatic idle_bus();
    bus_in    = 9'd0;
    bus_valid = 1'b0;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset_n    = 1'b0;
    bus_in     = 9'd0;
    bus_valid  = 1'b0;
    resp_ready = 1'b0;
    #1;
    chk("rst_valid", 9'(resp_valid), 9'd0);
    chk("rst_out",   resp_out,       9'd0);
    chk("rst_busy",  9'(busy),       9'd0);
    chk("rst_drop",  9'(drop_cnt),   9'd0);
    #22;
    reset_n = 1'b1;
    step();

    // Basic read miss, tag 5, latency 2.
    drive(bw(2'b01, 3'd5, 4'd0));
    step();
    idle_bus();
    chk("rm5_busy_T",   9'(busy),       9'd1);
    chk("rm5_valid_T",  9'(resp_valid), 9'd0);
    step();
    chk("rm5_valid_T1", 9'(resp_valid), 9'd0);
    step();
    chk("rm5_valid_T2", 9'(resp_valid), 9'd1);
    chk("rm5_out",      resp_out,       9'b10_101_0101);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("rm5_valid_T3", 9'(resp_valid), 9'd0);
    chk("rm5_busy_T3",  9'(busy),       9'd0);

    // Write-back in IDLE then read it back.
    drive(bw(2'b11, 3'd3, 4'hA));
    step();
    chk("wb3_busy", 9'(busy), 9'd0);
    drive(bw(2'b01, 3'd3, 4'd0));
    step();
    idle_bus();
    step();
    step();
    chk("rm3_valid", 9'(resp_valid), 9'd1);
    chk("rm3_out",   resp_out,       9'b10_011_1010);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Cache intervention aborts the access.
    drive(bw(2'b01, 3'd6, 4'd0));
    step();
    drive(bw(2'b10, 3'd6, 4'd0));
    step();
    idle_bus();
    chk("int6_busy",   9'(busy),       9'd0);
    chk("int6_valid",  9'(resp_valid), 9'd0);
    step();
    chk("int6_valid2", 9'(resp_valid), 9'd0);

    // ReadHit with another tag is ignored.
    drive(bw(2'b01, 3'd0, 4'd0));
    step();
    drive(bw(2'b10, 3'd7, 4'd0));
    step();
    idle_bus();
    chk("rh7_busy", 9'(busy), 9'd1);
    step();
    chk("rm0_out", resp_out, 9'b10_000_0000);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Write-back on the edge entering RESP is forwarded.
    drive(bw(2'b01, 3'd1, 4'd0));
    step();
    idle_bus();
    step();
    drive(bw(2'b11, 3'd1, 4'h7));
    step();
    idle_bus();
    chk("fwd1_valid", 9'(resp_valid), 9'd1);
    chk("fwd1_out",   resp_out,       9'b10_001_0111);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Stalled reply with 16 dropped read misses.
    drive(bw(2'b01, 3'd4, 4'd0));
    step();
    for (int i = 0; i < 16; i++) begin
      drive(bw(2'b01, 3'(i), 4'd0));
      step();
      if (i >= 1) begin
        chk("stall_out", resp_out, 9'b10_100_0100);
      end
    end
    idle_bus();
    chk("stall_valid", 9'(resp_valid), 9'd1);
    chk("drop_sat",    9'(drop_cnt),   9'd15);
    drive(bw(2'b11, 3'd4, 4'hF));
    step();
    idle_bus();
    chk("resp_wb_out", resp_out, 9'b10_100_0100);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("stall_done", 9'(busy), 9'd0);
    drive(bw(2'b01, 3'd4, 4'd0));
    step();
    idle_bus();
    step();
    step();
    chk("rm4_out", resp_out, 9'b10_100_1111);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Asynchronous reset mid-WAIT restores memory.
    drive(bw(2'b11, 3'd2, 4'h9));
    step();
    drive(bw(2'b01, 3'd2, 4'd0));
    step();
    idle_bus();
    chk("pre_rst_busy", 9'(busy), 9'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy",  9'(busy),       9'd0);
    chk("arst_valid", 9'(resp_valid), 9'd0);
    chk("arst_drop",  9'(drop_cnt),   9'd0);
    chk("arst_out",   resp_out,       9'd0);
    #2;
    reset_n = 1'b1;
    drive(bw(2'b01, 3'd2, 4'd0));
    step();
    idle_bus();
    chk("post_rst_busy", 9'(busy), 9'd1);
    step();
    step();
    chk("mem2_out", resp_out, 9'b10_010_0010);

    // Read miss on the handshake edge is dropped.
    resp_ready = 1'b1;
    drive(bw(2'b01, 3'd3, 4'd0));
    step();
    resp_ready = 1'b0;
    idle_bus();
    chk("hs_busy", 9'(busy),     9'd0);
    chk("hs_drop", 9'(drop_cnt), 9'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
